// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - ALU command queue, issue FSM and response holder
//
// alu_cmd_fifo
//   Command queue in front of the issue FSM.
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head_data         oldest entry
//   empty             no entries held
//   can_accept        registered "not full", held low during reset
//
// alu_cmd_issuer
//   Requester side of the ALU operand interface. Commands are queued, issued one
//   at a time on registered operand lines, and the ALU result is captured after
//   ALU_LATENCY cycles and returned on a valid/ready response port.
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   ena         enable; low freezes FSM and FIFO and forces cmd_ready low
//   cmd_valid   command present
//   cmd_ready   FIFO can accept a command
//   cmd_data    [2:0]=A, [5:3]=B, [7:6]=sel
//   alu_a       operand A to the ALU, registered
//   alu_b       operand B to the ALU, registered
//   alu_sel     operation select to the ALU, registered
//   alu_result  ALU result, combinational from alu_a/alu_b/alu_sel
//   rsp_valid   response held on rsp_data
//   rsp_ready   consumer accepts the response
//   rsp_data    [5:0]=captured result, [7:6]=issue tag or 0
//
// Build option ALU_CMD_ISSUER_TAG_EN: when defined, a 2-bit issue counter is
// returned on rsp_data[7:6]; when undefined those bits are tied to 0.

module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             can_accept
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push & (count != DEPTH_C);
    assign do_pop    = pop & (count != '0);
    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // can_accept is registered from the next count, so a pop in the same
    // cycle as a full FIFO does not open the door until the following cycle.
    // Resetting it low keeps cmd_ready low for the whole reset window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            can_accept <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_next;
            can_accept <= (count_next != DEPTH_C);
        end
    end

    // Storage needs no reset: the count decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module alu_cmd_issuer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [5:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data
);
    localparam logic [2:0] LAT_C = 3'(ALU_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [5:0] rsp_result;
    logic [1:0] rsp_tag;

    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       fifo_empty;
    logic       fifo_can_accept;

    assign cmd_ready = ena & fifo_can_accept;
    assign fifo_push = cmd_valid & cmd_ready;
    // The head is consumed on the same edge that loads it onto the operand lines.
    assign fifo_pop  = ena & (state == ST_ISSUE);
    assign rsp_data  = {rsp_tag, rsp_result};

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_data  (cmd_data),
        .pop        (fifo_pop),
        .head_data  (fifo_head),
        .empty      (fifo_empty),
        .can_accept (fifo_can_accept)
    );

`ifdef ALU_CMD_ISSUER_TAG_EN
    logic [1:0] issue_tag;
    logic [1:0] held_tag;
`else
    assign rsp_tag = 2'b00;
`endif

    // Operand lines are only written in ISSUE and keep the last command
    // between issues, so the combinational ALU never sees a spurious input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
`ifdef ALU_CMD_ISSUER_TAG_EN
            issue_tag  <= '0;
            held_tag   <= '0;
            rsp_tag    <= '0;
`endif
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    alu_a   <= fifo_head[2:0];
                    alu_b   <= fifo_head[5:3];
                    alu_sel <= fifo_head[7:6];
                    cnt     <= LAT_C;
                    state   <= ST_WAIT;
`ifdef ALU_CMD_ISSUER_TAG_EN
                    held_tag  <= issue_tag;
                    issue_tag <= issue_tag + 1'b1;
`endif
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 3'd1) begin
                        rsp_result <= alu_result;
                        rsp_valid  <= 1'b1;
                        state      <= ST_HOLD;
`ifdef ALU_CMD_ISSUER_TAG_EN
                        rsp_tag    <= held_tag;
`endif
                    end
                end
                ST_HOLD: begin
                    // A held response stalls issue; the queue keeps filling.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= fifo_empty ? ST_IDLE : ST_ISSUE;
                    end
                end
            endcase
        end
    end
endmodule
